// File: rtl/song_reader_pkg.sv
// song_reader_pkg: shared state encoding, ROM word layout and note-player field widths
package song_reader_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;
  localparam int END_BIT    = 15;
  localparam int STEREO_MSB = 14;
  localparam int STEREO_LSB = 13;
  localparam int NOTE_MSB   = 12;
  localparam int NOTE_LSB   = 7;
  localparam int DUR_MSB    = 6;
  localparam int DUR_LSB    = 1;
  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  function automatic logic [15:0] rom_word(input logic end_m, input logic [1:0] st,
                                           input logic [NOTE_W-1:0] note, input logic [DUR_W-1:0] dur);
    return {end_m, st, note, dur, 1'b0};
  endfunction
endpackage

// File: rtl/dffr.sv
// dffr: flip-flop bank with asynchronous active-high clear
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // plain register, cleared the moment reset rises
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= d;
endmodule

// File: rtl/dffre.sv
// dffre: flip-flop bank with load enable and asynchronous active-high clear
module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // register that only captures when enabled, cleared the moment reset rises
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/song_rom.sv
// song_rom: song table with registered address, one-cycle read latency
module song_rom
  import song_reader_pkg::*;
#(
  parameter int NUM_SONG_BITS = 2,
  parameter int NOTE_IDX_BITS = 5,
  parameter int ROM_WIDTH     = 16
) (
  input  logic                                   clk,
  input  logic [NUM_SONG_BITS+NOTE_IDX_BITS-1:0] addr,
  output logic [ROM_WIDTH-1:0]                   dout
);
  localparam logic [15:0] END_WORD = 16'h8000;
  logic [NUM_SONG_BITS-1:0] song;
  logic [NOTE_IDX_BITS-1:0] idx;
  logic [5:0] i6;
  logic [15:0] word;
  // address register; the table below is a pure decode of it
  always_ff @(posedge clk) {song, idx} <= addr;
  assign i6 = 6'(idx);
  // song 0: two notes, song 1: three notes, song 2: 32 notes with no marker, others: empty
  assign word =
    song == NUM_SONG_BITS'(0) ? (i6 == 6'd0 ? rom_word(1'b0, 2'b10, 6'd10, 6'd3) :
                                 i6 == 6'd1 ? rom_word(1'b0, 2'b11, 6'd11, 6'd4) : END_WORD) :
    song == NUM_SONG_BITS'(1) ? (i6 == 6'd0 ? rom_word(1'b0, 2'b01, 6'd20, 6'd5) :
                                 i6 == 6'd1 ? rom_word(1'b0, 2'b10, 6'd21, 6'd6) :
                                 i6 == 6'd2 ? rom_word(1'b0, 2'b11, 6'd22, 6'd0) : END_WORD) :
    song == NUM_SONG_BITS'(2) ? rom_word(1'b0, 2'b11, i6 | 6'd32, i6 + 6'd1) : END_WORD;
  assign dout = ROM_WIDTH'(word);
endmodule

// File: rtl/song_reader.sv
// song_reader: walks a ROM song and hands each note word to the note player
module song_reader
  import song_reader_pkg::*;
#(
  parameter int NUM_SONG_BITS = 2,
  parameter int NOTE_IDX_BITS = 5,
  parameter int ROM_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [NUM_SONG_BITS-1:0] song_sel,
  input  logic                     note_done,
  output logic [NOTE_W-1:0]        note_to_load,
  output logic [DUR_W-1:0]         duration_to_load,
  output logic [1:0]               stereo_side_to_load,
  output logic                     load_new_note,
  output logic                     song_done,
  output logic                     busy
);
  localparam int OUT_W = NOTE_W + DUR_W + 2;
  state_t state_q, state_d;
  logic [2:0] state_raw;
  logic play_q, armed, start, dec_load;
  logic [NUM_SONG_BITS-1:0] song_q;
  logic [NOTE_IDX_BITS-1:0] idx_q, idx_d;
  logic [ROM_WIDTH-1:0] rom_dout;
  logic [OUT_W-1:0] out_q;
  logic unused_rsvd;
  assign state_q = state_t'(state_raw);
  assign unused_rsvd = rom_dout[0];
  // armed only sets once play has been seen low, so a play level held through reset cannot start a song
  assign start = play & ~play_q & armed;
  assign busy = state_q != IDLE;
  assign song_done = state_q == DONE;
  assign {note_to_load, duration_to_load, stereo_side_to_load} = out_q;
  dffr #(.W(3)) u_state (.clk(clk), .reset(reset), .d(state_d), .q(state_raw));
  dffr #(.W(1)) u_play (.clk(clk), .reset(reset), .d(play), .q(play_q));
  dffr #(.W(1)) u_armed (.clk(clk), .reset(reset), .d(armed | ~play), .q(armed));
  dffr #(.W(NOTE_IDX_BITS)) u_idx (.clk(clk), .reset(reset), .d(idx_d), .q(idx_q));
  dffr #(.W(1)) u_load (.clk(clk), .reset(reset), .d(dec_load), .q(load_new_note));
  dffre #(.W(NUM_SONG_BITS)) u_song (
    .clk(clk), .reset(reset), .en(state_q == IDLE && start), .d(song_sel), .q(song_q)
  );
  dffre #(.W(OUT_W)) u_out (
    .clk(clk), .reset(reset), .en(dec_load),
    .d({rom_dout[NOTE_MSB:NOTE_LSB], rom_dout[DUR_MSB:DUR_LSB], rom_dout[STEREO_MSB:STEREO_LSB]}),
    .q(out_q)
  );
  song_rom #(
    .NUM_SONG_BITS(NUM_SONG_BITS), .NOTE_IDX_BITS(NOTE_IDX_BITS), .ROM_WIDTH(ROM_WIDTH)
  ) u_rom (
    .clk(clk), .addr({song_q, idx_q}), .dout(rom_dout)
  );
  // next state and index; a note_done coinciding with the load strobe belongs to no note yet
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    dec_load = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        idx_d = '0;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        dec_load = ~rom_dout[END_BIT];
        state_d = rom_dout[END_BIT] ? DONE : WAIT_DONE;
      end
      WAIT_DONE: if (note_done && !load_new_note) begin
        state_d = &idx_q ? DONE : FETCH;
        idx_d = &idx_q ? idx_q : idx_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
